// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS MEM stage: word-addressed RAM with a
// fixed, parameterised access latency, stalling the pipeline while busy.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        mem_adv,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [31:0]             lat_data;
    logic                    lat_we;
    logic                    latch_en;
    logic                    err_nxt;

    logic                    req;
    logic                    aligned;
    logic [ADDR_WIDTH-1:0]   req_idx;

    logic                    acc_en;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_data;

    logic [31:0]             ram [DEPTH];

    // Upper byte-address bits are deliberately dropped so addresses wrap.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

    assign req     = mem_ren | mem_wen;
    assign aligned = (mem_addr[1:0] == 2'b00);
    assign req_idx = mem_addr[ADDR_WIDTH+1:2];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        err_nxt   = 1'b0;
        mem_stall = 1'b0;
        acc_en    = 1'b0;
        acc_we    = lat_we;
        acc_idx   = lat_idx;
        acc_data  = lat_data;

        case (state)
            IDLE: begin
                if (req) begin
                    if (aligned) begin
                        mem_stall = 1'b1;
                        latch_en  = 1'b1;
                        cnt_nxt   = WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            // Zero latency: access straight from the request inputs.
                            state_nxt = DONE;
                            acc_en    = 1'b1;
                            acc_we    = mem_wen;
                            acc_idx   = req_idx;
                            acc_data  = mem_dout;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                cnt_nxt   = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    acc_en    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (mem_adv) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Stall is combinational, so reset must mask it explicitly.
        if (rst) begin
            mem_stall = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, giving read-before-write on mem_din for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_idx  <= '0;
            lat_data <= 32'd0;
            lat_we   <= 1'b0;
            mem_din  <= 32'd0;
            mem_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mem_err <= err_nxt;
            if (latch_en) begin
                lat_idx  <= req_idx;
                lat_data <= mem_dout;
                lat_we   <= mem_wen;
            end
            if (acc_en) begin
                mem_din <= ram[acc_idx];
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; a write
    // that coincides with reset is suppressed instead.
    always_ff @(posedge clk) begin
        if (acc_en && acc_we && !rst) begin
            ram[acc_idx] <= acc_data;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a WAIT_CYCLES=2 instance driven by
// directed accesses, plus a WAIT_CYCLES=0 instance for the zero-latency path.
module tb_data_mem_responder;

    localparam int W = 2;

    typedef struct {
        bit          is_err;
        bit          care;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ren = 1'b0, wen = 1'b0, adv = 1'b0;
    logic [31:0] addr = 32'd0, dout = 32'd0;
    logic [31:0] din;
    logic        stall, err;

    logic        ren0 = 1'b0, wen0 = 1'b0, adv0 = 1'b0;
    logic [31:0] addr0 = 32'd0, dout0 = 32'd0;
    logic [31:0] din0;
    logic        stall0, err0;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        stall_prev = 1'b0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
        .mem_dout(dout), .mem_adv(adv), .mem_din(din), .mem_stall(stall),
        .mem_err(err)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_ren(ren0), .mem_wen(wen0), .mem_addr(addr0),
        .mem_dout(dout0), .mem_adv(adv0), .mem_din(din0), .mem_stall(stall0),
        .mem_err(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a falling stall edge presents read data, an err pulse presents
    // a misalignment; each pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (err) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_err_unexpected: got err=1 with empty scoreboard");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_err_kind", 32'(e.is_err), 32'd1);
                end
            end
            if (stall_prev && !stall) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_resp_unexpected: got din=%h with empty scoreboard", din);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_resp_kind", 32'(e.is_err), 32'd0);
                    if (e.care) check("sb_resp_data", din, e.data);
                end
            end
        end
        stall_prev = rst ? 1'b0 : stall;
    end

    // Starts and ends at posedge+1 with the DUT in IDLE.
    task automatic do_access(input string tag, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp,
                             input bit care, input int hold);
        int n;
        ren  = ~we;
        wen  = we;
        addr = a;
        dout = d;
        adv  = 1'b0;
        sb.push_back('{is_err: 1'b0, care: care, data: exp});
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) n++;
            else break;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'(W + 1));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 dout = ~d;
            @(negedge clk);
            check({tag, "_hold_stall"}, 32'(stall), 32'd0);
            if (care) check({tag, "_hold_din"}, din, exp);
        end
        adv = 1'b1;
        ren = 1'b0;
        wen = 1'b0;
        @(posedge clk);
        #1 adv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with an aligned request present to prove stall is masked.
        ren  = 1'b1;
        addr = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        check("rst_din", din, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_din", din, 32'd0);

        // Write then read back.
        do_access("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_access("rd10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 0);

        // Read-before-write.
        do_access("wr20a", 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 0);
        do_access("wr20b", 1'b1, 32'h20, 32'h22222222, 32'h11111111, 1'b1, 0);
        do_access("rd20", 1'b0, 32'h20, 32'h0, 32'h22222222, 1'b1, 0);

        // Misaligned read: err for exactly one cycle, never a stall.
        ren  = 1'b1;
        addr = 32'h13;
        sb.push_back('{is_err: 1'b1, care: 1'b1, data: 32'h0});
        @(negedge clk);
        check("mis_stall_n", 32'(stall), 32'd0);
        check("mis_err_n", 32'(err), 32'd0);
        @(posedge clk);
        #1 ren = 1'b0;
        @(negedge clk);
        check("mis_err_n1", 32'(err), 32'd1);
        check("mis_stall_n1", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mis_err_n2", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // Wrap-around: 0x1004 and 0x0004 share word index 1.
        do_access("wr1004", 1'b1, 32'h1004, 32'h5, 32'h0, 1'b0, 0);
        do_access("rd0004", 1'b0, 32'h4, 32'h0, 32'h5, 1'b1, 0);
        do_access("rd1010", 1'b0, 32'h1010, 32'h0, 32'hDEADBEEF, 1'b1, 0);

        // DONE hold: request stays asserted and write data changes meanwhile.
        do_access("holdwr", 1'b1, 32'h20, 32'h44444444, 32'h22222222, 1'b1, 5);
        do_access("holdrd", 1'b0, 32'h20, 32'h0, 32'h44444444, 1'b1, 5);

        // Reset in the second WAIT cycle of a write discards it.
        do_access("wr80", 1'b1, 32'h80, 32'h1234, 32'h0, 1'b0, 0);
        wen  = 1'b1;
        addr = 32'h80;
        dout = 32'hABCD;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst = 1'b1;
        wen = 1'b0;
        #1;
        check("rstmid_din", din, 32'd0);
        check("rstmid_stall", 32'(stall), 32'd0);
        check("rstmid_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_access("rd80", 1'b0, 32'h80, 32'h0, 32'h1234, 1'b1, 0);

        // Zero-latency instance with ren and wen both high (treated as write).
        ren0  = 1'b1;
        wen0  = 1'b1;
        addr0 = 32'h40;
        dout0 = 32'h7;
        @(negedge clk);
        check("w0_wr_stall_n", 32'(stall0), 32'd1);
        @(posedge clk);
        #1 adv0 = 1'b1;
        @(negedge clk);
        check("w0_wr_stall_n1", 32'(stall0), 32'd0);
        @(posedge clk);
        #1 adv0 = 1'b0;
        wen0 = 1'b0;
        @(negedge clk);
        check("w0_rd_stall_n", 32'(stall0), 32'd1);
        @(posedge clk);
        #1 adv0 = 1'b1;
        ren0 = 1'b0;
        @(negedge clk);
        check("w0_rd_stall_n1", 32'(stall0), 32'd0);
        check("w0_rd_din", din0, 32'h7);
        @(posedge clk);
        #1 adv0 = 1'b0;

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
